// File: rtl/econet_line_arbiter_if.sv
// Handshake bundle between the MCU pins, the econet core and the line arbiter.
// The arbiter takes the slave view; the environment driving it takes the master view.
interface econet_line_arbiter_if;
    logic econet_clock_R;
    logic econet_data_R;
    logic econet_data_D;
    logic econet_data_DE;
    logic outputting_frame;
    logic tx_request;
    logic tx_grant;
    logic mcu_is_transmitting;
    logic line_idle;
    logic clock_lost;
    logic tx_done;
    logic tx_abort;
    logic collision;

    modport slave (
        input  econet_clock_R, econet_data_R, econet_data_D, econet_data_DE,
        input  outputting_frame, tx_request,
        output tx_grant, mcu_is_transmitting, line_idle, clock_lost,
        output tx_done, tx_abort, collision
    );

    modport master (
        output econet_clock_R, econet_data_R, econet_data_D, econet_data_DE,
        output outputting_frame, tx_request,
        input  tx_grant, mcu_is_transmitting, line_idle, clock_lost,
        input  tx_done, tx_abort, collision
    );
endinterface

// File: rtl/econet_line_arbiter.sv
// Econet line arbiter: detects a free line from the received bus, grants MCU transmit
// requests and aborts on collision, Econet clock loss or an unused grant.
module econet_line_arbiter #(
    parameter int unsigned IDLE_BITS         = 15,
    parameter int unsigned CLOCK_LOSS_CYCLES = 2400,
    parameter int unsigned GRANT_TIMEOUT     = 48000
) (
    input logic            clock,
    input logic            reset_n,
    econet_line_arbiter_if.slave bus
);
    localparam int unsigned IdleW = $clog2(IDLE_BITS + 1);
    localparam int unsigned LossW = $clog2(CLOCK_LOSS_CYCLES + 1);
    localparam int unsigned TmrW  = $clog2(GRANT_TIMEOUT + 1);
    localparam logic [IdleW-1:0] IdleMax = IdleW'(IDLE_BITS);
    localparam logic [LossW-1:0] LossMax = LossW'(CLOCK_LOSS_CYCLES);
    localparam logic [TmrW-1:0]  TmrMax  = TmrW'(GRANT_TIMEOUT);

    typedef enum logic [2:0] {
        StIdle, StWait, StGrant, StActive, StDrain, StAbort, StHold
    } state_e;

    state_e           state_q, state_d;
    logic             clk_s1_q, clk_s2_q, clk_prev_q;
    logic             data_s1_q, data_s2_q;
    logic [1:0]       d_dly_q, de_dly_q;
    logic             of_prev_q;
    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
    logic [LossW-1:0] loss_cnt_q, loss_cnt_d;
    logic [TmrW-1:0]  grant_tmr_q, grant_tmr_d;
    logic             line_idle_q, line_idle_d;
    logic             clock_lost_q, clock_lost_d;
    logic             collision_q, collision_d;
    logic             drain_cnt_q, drain_cnt_d;
    logic             tx_done_q, tx_done_d;
    logic             rise_evt, edge_evt, coll_set, of_rise, of_fall;

    assign rise_evt = clk_s2_q & ~clk_prev_q;
    assign edge_evt = clk_s2_q ^ clk_prev_q;
    assign of_rise  = bus.outputting_frame & ~of_prev_q;
    assign of_fall  = ~bus.outputting_frame & of_prev_q;

    // Driven value is delayed to line up with the synchronised received data.
    assign coll_set = rise_evt && (state_q == StActive) && de_dly_q[1] && d_dly_q[1]
                      && !data_s2_q;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (edge_evt) begin
            loss_cnt_d = '0;
        end else if (loss_cnt_q != LossMax) begin
            loss_cnt_d = loss_cnt_q + LossW'(1);
        end
        // Held from reset until the first edge is seen, as well as after a timeout.
        clock_lost_d = !edge_evt && (clock_lost_q || (loss_cnt_d == LossMax));

        idle_cnt_d = idle_cnt_q;
        if (clock_lost_d) begin
            idle_cnt_d = '0;
        end else if (rise_evt) begin
            if (!data_s2_q) begin
                idle_cnt_d = '0;
            end else if (idle_cnt_q != IdleMax) begin
                idle_cnt_d = idle_cnt_q + IdleW'(1);
            end
        end
        line_idle_d = (idle_cnt_d == IdleMax);
        collision_d = bus.tx_request && (collision_q || coll_set);
    end

    always_comb begin
        state_d     = state_q;
        grant_tmr_d = '0;
        drain_cnt_d = drain_cnt_q;
        tx_done_d   = 1'b0;
        unique case (state_q)
            StIdle: if (bus.tx_request) state_d = StWait;
            StWait: begin
                if (!bus.tx_request) begin
                    state_d = StIdle;
                end else if (line_idle_q && !clock_lost_q) begin
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (!bus.tx_request || clock_lost_q || (grant_tmr_q == TmrMax)) begin
                    state_d = StAbort;
                end else if (of_rise) begin
                    state_d = StActive;
                end else begin
                    grant_tmr_d = grant_tmr_q + TmrW'(1);
                end
            end
            StActive: begin
                if (coll_set || collision_q || clock_lost_q) begin
                    state_d = StAbort;
                end else if (of_fall) begin
                    state_d     = StDrain;
                    drain_cnt_d = 1'b0;
                end
            end
            StDrain: begin
                // Without a clock the closing flag can never finish shifting out.
                if (clock_lost_q) begin
                    state_d = StAbort;
                end else if (rise_evt) begin
                    if (drain_cnt_q) begin
                        state_d   = StHold;
                        tx_done_d = 1'b1;
                    end else begin
                        drain_cnt_d = 1'b1;
                    end
                end
            end
            StAbort: state_d = StHold;
            StHold:  if (!bus.tx_request) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            clk_s1_q     <= 1'b0;
            clk_s2_q     <= 1'b0;
            clk_prev_q   <= 1'b0;
            data_s1_q    <= 1'b0;
            data_s2_q    <= 1'b0;
            d_dly_q      <= '0;
            de_dly_q     <= '0;
            of_prev_q    <= 1'b0;
            idle_cnt_q   <= '0;
            loss_cnt_q   <= '0;
            grant_tmr_q  <= '0;
            line_idle_q  <= 1'b0;
            clock_lost_q <= 1'b1;
            collision_q  <= 1'b0;
            drain_cnt_q  <= 1'b0;
            tx_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_s1_q     <= bus.econet_clock_R;
            clk_s2_q     <= clk_s1_q;
            clk_prev_q   <= clk_s2_q;
            data_s1_q    <= bus.econet_data_R;
            data_s2_q    <= data_s1_q;
            d_dly_q      <= {d_dly_q[0], bus.econet_data_D};
            de_dly_q     <= {de_dly_q[0], bus.econet_data_DE};
            of_prev_q    <= bus.outputting_frame;
            idle_cnt_q   <= idle_cnt_d;
            loss_cnt_q   <= loss_cnt_d;
            grant_tmr_q  <= grant_tmr_d;
            line_idle_q  <= line_idle_d;
            clock_lost_q <= clock_lost_d;
            collision_q  <= collision_d;
            drain_cnt_q  <= drain_cnt_d;
            tx_done_q    <= tx_done_d;
        end
    end

    assign bus.tx_grant            = (state_q == StGrant) || (state_q == StActive);
    assign bus.mcu_is_transmitting = (state_q == StGrant) || (state_q == StActive)
                                     || (state_q == StDrain);
    assign bus.tx_abort            = (state_q == StAbort);
    assign bus.tx_done             = tx_done_q;
    assign bus.line_idle           = line_idle_q;
    assign bus.clock_lost          = clock_lost_q;
    assign bus.collision           = collision_q;
endmodule
